memory_dump_tx: RTL and testbench
=================================

# memory_dump_tx

- Reads a 32-word x 16-bit program memory through its read port and streams every word out over UART TX, high byte first.
- This is the exact inverse of the UART program-load path, so a host can read back and verify what it loaded.
- Sits beside the instruction memory and shares its combinational read port while the CPU is held.
- Drives the board UART transmit pin.

## Interface
- CLOCKS_PER_BAUD, 868, clock cycles per UART bit (100 MHz / 115200).
- ADDR_W, 5, memory address width; word count = 2**ADDR_W.
- WORD_W, 16, memory word width; fixed at two bytes.
- CLK  input  1  system clock; sole clock domain.
- RST  input  1  reset; asynchronous, active-high.
- start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
- rd_addr  output  ADDR_W  memory read address, registered.
- rd_data  input  WORD_W  memory read data; combinational read of rd_addr.
- UART_RXD_OUT  output  1  serial TX line, idle high, 8N1, LSB first.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse after the final stop bit.

## Operation
- Reset values: UART_RXD_OUT=1, busy=0, done=0, rd_addr=0, FSM=IDLE, checksum=0.
- FSM states:
  - IDLE: on start, go to LOAD, set busy=1 and rd_addr=0.
  - LOAD: latch rd_data into word_q, go to TX_HI.
  - TX_HI: issue word_q[15:8] to the serializer, wait for the frame to complete, go to TX_LO.
  - TX_LO: issue word_q[7:0], wait for the frame to complete.
    - If rd_addr==2**ADDR_W-1, go to FINISH (or TX_CK when checksum is enabled).
    - Otherwise increment rd_addr and go to LOAD.
  - FINISH: pulse done, clear busy, go to IDLE.
- Total payload is 64 bytes, in address order 0..31, with each word sent as its high byte then its low byte.
- rd_addr wraps to 0 when returning to IDLE. It never increments past 31.
- start while busy=1 is ignored and is not queued.
- start in the same cycle as done is ignored; it must be reasserted in IDLE.
- Memory contents changing mid-dump is outside this block's responsibility. A word is captured once, in LOAD.
- RST mid-frame forces the line high immediately. The truncated frame is accepted, and the FSM returns to IDLE.

## Timing
- Bit period is exactly CLOCKS_PER_BAUD cycles.
- Each frame is 10 bit periods: 1 start bit, 8 data bits, 1 stop bit.
- The start bit begins on the cycle after the serializer accepts a byte.
- Latency from the start pulse to the falling edge of the first start bit is 3 cycles: IDLE→LOAD, LOAD→TX_HI, then the write is accepted.
- Idle gap between frames:
  - Exactly 1 cycle between the stop bit of the high byte and the start bit of the low byte.
  - Exactly 2 cycles between the stop bit of a low byte and the start bit of the next high byte, because of the LOAD cycle.
- done asserts 1 cycle after the final stop bit period ends. busy falls in that same cycle.
- The serializer handshake is i_wr/o_busy. i_wr is honoured only when o_busy=0. o_busy rises the cycle after i_wr and falls after the last stop-bit cycle.

## Configuration
- DUMP_CHECKSUM_EN defined:
  - A running XOR of every transmitted payload byte is kept.
  - After the last word, a TX_CK state sends that checksum as byte 65, then goes to FINISH.
  - The checksum clears on start acceptance and on RST.
- DUMP_CHECKSUM_EN undefined: there is no checksum register or TX_CK state, and exactly 64 bytes are sent.

## Structure
- Shared package holds:
  - The FSM state encoding: IDLE, LOAD, TX_HI, TX_LO, TX_CK, FINISH.
  - The bytes-per-word constant (2).
  - The default CLOCKS_PER_BAUD.
- One sub-module, uart_tx_byte, is the 8N1 serializer:
  - Holds the baud counter, bit index and shift register.
  - Ports: CLK, RST, i_wr, i_data[7:0], o_busy, o_tx.
  - It is the transmit counterpart of the existing receiver and shares its CLOCKS_PER_BAUD.

## Test plan
- Use CLOCKS_PER_BAUD=4 in simulation.
- Reset: assert RST for 3 cycles. Expect UART_RXD_OUT=1, busy=0, done=0 and rd_addr=0 throughout, with no activity for 100 cycles after release.
- Single word: memory[0]=16'h4008, others 0, pulse start.
  - First frame bits are 0,0,0,0,0,0,0,1,0,1, i.e. 0x40.
  - Second frame is 0x08.
  - First start bit falls 3 cycles after start.
- Full dump: memory[i]=16'h1100+i.
  - Decoder captures 64 bytes in order: 11,00,11,01 … 11,1F.
  - done pulses exactly once, busy is high for the whole dump, and rd_addr ends at 0.
- Gaps: measure idle cycles between frames. Expect 1 cycle after each high byte and 2 cycles after each low byte.
- start while busy: pulse start at byte 10. Expect the byte count to stay 64 and no second dump to begin. Then pulse start in IDLE and expect a fresh 64-byte dump.
- Reset mid-frame and checksum:
  - Assert RST during bit 4 of byte 7. Expect the line high the next cycle and busy=0, and a later start to restart from address 0.
  - With DUMP_CHECKSUM_EN and memory[0]=16'h4008, others 0, expect byte 65 = 0x48.

Source files
------------

// File: rtl/memory_dump_tx_pkg.sv
// Shared definitions for the memory dump transmitter.
// Optional feature macro: DUMP_CHECKSUM_EN (adds the trailing XOR checksum byte).
package memory_dump_tx_pkg;

    localparam int unsigned BYTES_PER_WORD          = 2;
    localparam int unsigned DEFAULT_CLOCKS_PER_BAUD = 868;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        TX_HI,
        TX_LO,
`ifdef DUMP_CHECKSUM_EN
        TX_CK,
`endif
        FINISH
    } state_t;

endpackage

// File: rtl/memory_dump_tx_if.sv
// Control and memory read-port bundle between the dump engine and its host side.
interface memory_dump_tx_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned WORD_W = 16
);
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rd_addr;
    logic [WORD_W-1:0] rd_data;

    modport master (
        output start,
        output rd_data,
        input  busy,
        input  done,
        input  rd_addr
    );

    modport slave (
        input  start,
        input  rd_data,
        output busy,
        output done,
        output rd_addr
    );
endinterface

// File: rtl/memory_dump_tx_uart_tx_byte.sv
// 8N1 UART byte serializer: start bit, 8 data bits LSB first, stop bit.
// o_busy drops during the final stop-bit cycle so a follow-on write lands
// exactly when the stop bit ends.
module uart_tx_byte #(
    parameter int unsigned CLOCKS_PER_BAUD = memory_dump_tx_pkg::DEFAULT_CLOCKS_PER_BAUD
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       i_wr,
    input  logic [7:0] i_data,
    output logic       o_busy,
    output logic       o_tx
);

    localparam int unsigned      CNT_W    = (CLOCKS_PER_BAUD > 1) ? $clog2(CLOCKS_PER_BAUD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BAUD - 1);
    localparam logic [3:0]       BIT_STOP = 4'd9;

    logic             r_active;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_bit;
    logic [7:0]       r_shift;
    logic             r_tx;

    logic w_bit_end;
    logic w_last;
    logic w_accept;

    assign w_bit_end = (r_cnt == CNT_LAST);
    assign w_last    = r_active && w_bit_end && (r_bit == BIT_STOP);
    assign o_busy    = r_active && !w_last;
    assign w_accept  = i_wr && !o_busy;
    assign o_tx      = r_tx;

    // Baud counter, bit index and shift register; line idles high.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
        end else if (w_accept) begin
            r_active <= 1'b1;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_shift  <= i_data;
            r_tx     <= 1'b0;
        end else if (r_active) begin
            if (w_bit_end) begin
                r_cnt <= '0;
                if (r_bit == BIT_STOP) begin
                    r_active <= 1'b0;
                end else begin
                    // After eight shifts the register holds all ones, giving the stop bit.
                    r_bit   <= r_bit + 4'd1;
                    r_tx    <= r_shift[0];
                    r_shift <= {1'b1, r_shift[7:1]};
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/memory_dump_tx.sv
// Streams the whole program memory out over UART, high byte of each word first.
// Optional feature macro: DUMP_CHECKSUM_EN appends the XOR of all payload bytes.
module memory_dump_tx
    import memory_dump_tx_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_BAUD = DEFAULT_CLOCKS_PER_BAUD,
    parameter int unsigned ADDR_W          = 5,
    parameter int unsigned WORD_W          = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    memory_dump_tx_if.slave         bus,
    output logic                    UART_RXD_OUT
);

    localparam int unsigned HI_TOP = BYTES_PER_WORD * 8 - 1;

    state_t            r_state;
    state_t            w_next;
    logic              r_sent;
    logic [ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0] r_word;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]        r_cksum;
`endif

    logic       w_wr;
    logic [7:0] w_data;
    logic       w_tx_busy;
    logic       w_frame_done;
    logic       w_last_word;
    logic       w_busy;
    logic       w_done;

    assign w_frame_done = r_sent && !w_tx_busy;
    assign w_last_word  = (r_addr == '1);

    assign bus.rd_addr = r_addr;
    assign bus.busy    = w_busy;
    assign bus.done    = w_done;

    uart_tx_byte #(
        .CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)
    ) u_tx (
        .CLK    (CLK),
        .RST    (RST),
        .i_wr   (w_wr),
        .i_data (w_data),
        .o_busy (w_tx_busy),
        .o_tx   (UART_RXD_OUT)
    );

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:   if (bus.start) w_next = LOAD;
            LOAD:   w_next = TX_HI;
            TX_HI:  if (w_frame_done) w_next = TX_LO;
            TX_LO: begin
                if (w_frame_done) begin
                    if (!w_last_word) begin
                        w_next = LOAD;
                    end else begin
`ifdef DUMP_CHECKSUM_EN
                        w_next = TX_CK;
`else
                        w_next = FINISH;
`endif
                    end
                end
            end
`ifdef DUMP_CHECKSUM_EN
            TX_CK:  if (w_frame_done) w_next = FINISH;
`endif
            FINISH: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Serializer write strobe, byte select and status outputs.
    always_comb begin
        w_wr   = 1'b0;
        w_data = r_word[7:0];
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            LOAD: w_busy = 1'b1;
            TX_HI: begin
                w_busy = 1'b1;
                w_wr   = !r_sent;
                w_data = r_word[HI_TOP -: 8];
            end
            TX_LO: begin
                w_busy = 1'b1;
                w_wr   = !r_sent;
                w_data = r_word[7:0];
            end
`ifdef DUMP_CHECKSUM_EN
            TX_CK: begin
                w_busy = 1'b1;
                w_wr   = !r_sent;
                w_data = r_cksum;
            end
`endif
            FINISH: w_done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: one-shot write flag per TX state, address walk and word capture.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sent <= 1'b0;
            r_addr <= '0;
            r_word <= '0;
        end else begin
            r_sent <= (w_next == r_state) ? (r_sent | w_wr) : 1'b0;
            case (r_state)
                IDLE:   if (bus.start) r_addr <= '0;
                LOAD:   r_word <= bus.rd_data;
                TX_LO:  if (w_frame_done && !w_last_word) r_addr <= r_addr + 1'b1;
                FINISH: r_addr <= '0;
                default: ;
            endcase
        end
    end

`ifdef DUMP_CHECKSUM_EN
    // Running XOR of every payload byte handed to the serializer.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cksum <= '0;
        end else if (r_state == IDLE && bus.start) begin
            r_cksum <= '0;
        end else if (w_wr && (r_state == TX_HI || r_state == TX_LO)) begin
            r_cksum <= r_cksum ^ w_data;
        end
    end
`endif

endmodule

// File: tb/tb_memory_dump_tx.sv
// Self-checking bench for memory_dump_tx with a line-level UART decoder
// and a byte-stream reference model built from the memory image.
module tb_memory_dump_tx;

    localparam int CPB    = 4;
    localparam int NWORDS = 32;
    localparam int LIMIT  = 6000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic line;
    logic [15:0] mem [NWORDS];

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    memory_dump_tx_if #(.ADDR_W(5), .WORD_W(16)) bus ();

    assign bus.rd_data = mem[bus.rd_addr];

    memory_dump_tx #(
        .CLOCKS_PER_BAUD(CPB),
        .ADDR_W(5),
        .WORD_W(16)
    ) dut (
        .CLK          (clk),
        .RST          (rst),
        .bus          (bus),
        .UART_RXD_OUT (line)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- line decoder (samples mid-bit on negedge) ----------------
    logic [7:0] rx_q[$];
    int         rxs_q[$];
    int         done_q[$];
    int         busy_hi = 0;
    int         ferr    = 0;
    bit         mon_act = 0;
    int         mon_ph  = 0;
    int         mon_s   = 0;
    logic [9:0] mon_bits;

    initial begin
        forever begin
            @(negedge clk);
            if (bus.done) done_q.push_back(cyc);
            if (bus.busy) busy_hi++;
            if (rst) begin
                mon_act = 0;
            end else if (!mon_act) begin
                if (!line) begin
                    mon_act = 1;
                    mon_ph  = 0;
                    mon_s   = cyc;
                end
            end else begin
                mon_ph++;
            end
            if (mon_act && (mon_ph % CPB) == CPB / 2) begin
                mon_bits[mon_ph / CPB] = line;
                if (mon_ph / CPB == 9) begin
                    if (mon_bits[0] !== 1'b0 || mon_bits[9] !== 1'b1) ferr++;
                    rx_q.push_back(mon_bits[8:1]);
                    rxs_q.push_back(mon_s);
                    mon_act = 0;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] exp_q[$];

    task automatic build_expected();
        logic [15:0] w;
        logic [7:0]  ck;
        exp_q.delete();
        ck = 8'h00;
        for (int i = 0; i < NWORDS; i++) begin
            w = mem[i];
            exp_q.push_back(w[15:8]);
            exp_q.push_back(w[7:0]);
            ck = ck ^ w[15:8] ^ w[7:0];
        end
`ifdef DUMP_CHECKSUM_EN
        exp_q.push_back(ck);
`endif
    endtask

    // Idle cycles expected after frame k: 1 after a high byte (and before the checksum), 2 after a low byte.
    function automatic int exp_gap(input int k);
        return ((k % 2) == 0 || k == 2 * NWORDS - 1) ? 1 : 2;
    endfunction

    task automatic run_dump(input string tag, input int poke_at, input bit start_on_done);
        int base, dbase, bhi0, st, nb, waited, gap_bad, first_bad, exp_done, got_gap;
        bit seen_done, poked;
        build_expected();
        nb    = exp_q.size();
        base  = rx_q.size();
        dbase = done_q.size();
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        st   = cyc;
        bhi0 = busy_hi;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        seen_done = 0;
        poked     = 0;
        waited    = 0;
        while (!seen_done && waited < LIMIT) begin
            @(negedge clk);
            waited++;
            if (bus.done) seen_done = 1;
            if (!seen_done && poke_at >= 0 && !poked && rx_q.size() == base + poke_at) begin
                bus.start = 1'b1;
                poked = 1;
                @(negedge clk);
                waited++;
                bus.start = 1'b0;
            end
        end
        check({tag, " done_seen"}, 32'(seen_done), 32'd1);
        if (start_on_done && seen_done) begin
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
        repeat (60) @(negedge clk);

        check({tag, " nbytes"}, 32'(rx_q.size() - base), 32'(nb));
        for (int k = 0; k < nb && base + k < rx_q.size(); k++) begin
            check($sformatf("%s byte%0d", tag, k), 32'(rx_q[base + k]), 32'(exp_q[k]));
        end
        if (rx_q.size() > base) check({tag, " latency"}, 32'(rxs_q[base] - st), 32'd3);

        gap_bad = 0;
        first_bad = -1;
        for (int k = 0; k + 1 < nb && base + k + 1 < rxs_q.size(); k++) begin
            got_gap = rxs_q[base + k + 1] - rxs_q[base + k] - 10 * CPB;
            if (got_gap != exp_gap(k)) begin
                gap_bad++;
                if (first_bad < 0) first_bad = k;
            end
        end
        check({tag, " gap_errors"}, 32'(gap_bad), 32'd0);
        if (first_bad >= 0) $display("  first bad gap after frame %0d", first_bad);

        check({tag, " done_pulses"}, 32'(done_q.size() - dbase), 32'd1);
        exp_done = st + 3 + nb * 10 * CPB;
        for (int k = 0; k + 1 < nb; k++) exp_done += exp_gap(k);
        if (done_q.size() > dbase) begin
            check({tag, " done_cycle"}, 32'(done_q[dbase]), 32'(exp_done));
            check({tag, " busy_cycles"}, 32'(busy_hi - bhi0), 32'(done_q[dbase] - st - 1));
        end
        check({tag, " rd_addr_end"}, 32'(bus.rd_addr), 32'd0);
        check({tag, " framing"}, 32'(ferr), 32'd0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < NWORDS; i++) mem[i] = 16'($urandom);
    endtask

    initial begin
        int viol, base, waited;
        bit found;
        bus.start = 1'b0;
        for (int i = 0; i < NWORDS; i++) mem[i] = 16'h0000;

        // Reset: 3 cycles asserted, then 100 quiet cycles.
        @(negedge clk);
        check("rst line", 32'(line), 32'd1);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst done", 32'(bus.done), 32'd0);
        check("rst rd_addr", 32'(bus.rd_addr), 32'd0);
        viol = 0;
        repeat (2) begin
            @(negedge clk);
            if (line !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rd_addr !== 5'd0) viol++;
        end
        rst = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (line !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rd_addr !== 5'd0) viol++;
        end
        check("reset_quiet", 32'(viol), 32'd0);

        // Single word.
        mem[0] = 16'h4008;
        base = rx_q.size();
        run_dump("single", -1, 0);
        if (rx_q.size() >= base + 2) begin
            check("single first_byte", 32'(rx_q[base]), 32'h40);
            check("single second_byte", 32'(rx_q[base + 1]), 32'h08);
        end
`ifdef DUMP_CHECKSUM_EN
        if (rx_q.size() >= base + 65) check("single checksum", 32'(rx_q[base + 64]), 32'h48);
`endif

        // Full dump with an address-derived pattern.
        for (int i = 0; i < NWORDS; i++) mem[i] = 16'h1100 + 16'(i);
        run_dump("full", -1, 0);

        // Random image, start pulsed while busy at byte 10.
        fill_random();
        run_dump("start_busy", 10, 0);

        // Random image, start asserted in the done cycle.
        fill_random();
        run_dump("start_done", -1, 1);

        // Fresh dump from IDLE.
        fill_random();
        run_dump("fresh", -1, 0);

        // Reset during bit 4 of byte 7.
        fill_random();
        base = rx_q.size();
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        found = 0;
        waited = 0;
        while (!found && waited < LIMIT) begin
            @(negedge clk);
            waited++;
            if (rx_q.size() == base + 7 && mon_act && mon_ph == 4 * CPB + 1) found = 1;
        end
        check("midrst reached", 32'(found), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst line", 32'(line), 32'd1);
        check("midrst busy", 32'(bus.busy), 32'd0);
        check("midrst rd_addr", 32'(bus.rd_addr), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        viol = 0;
        repeat (30) begin
            @(negedge clk);
            if (line !== 1'b1 || bus.busy !== 1'b0) viol++;
        end
        check("midrst quiet", 32'(viol), 32'd0);
        check("midrst bytes", 32'(rx_q.size() - base), 32'd7);
        fill_random();
        run_dump("after_rst", -1, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
